bram_save_ctrl: RTL and testbench
=================================

# bram_save_ctrl

Sequencer for the PC Engine backup RAM (BRAM) save/load path. It moves the 8 KB backup image between the dual-port BRAM (port B) and the HPS SD-image interface as 16 sectors of 256 16-bit words. It also handles autosave, auto-load after cart download, and the format operation. It sits in the emu top level between hps_io, the backram_l/backram_h pair and the core reset.

## Interface
Parameters:
- SECTORS, 16: sectors per image; must be a power of 2.
- LBA_W, 4: log2(SECTORS).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- downloading  in  1  cart download in progress.
- img_mounted  in  1  one-cycle pulse when a save image is mounted.
- img_readonly  in  1  mounted image is read-only.
- img_nonempty  in  1  |img_size.
- load_req, save_req, format_req  in  1 each  OSD levels; the block edge-detects them internally.
- autosave_en  in  1  autosave option.
- osd_open  in  1  OSD is visible.
- core_wr  in  1  core writes BRAM.
- sd_lba  out  32  sector number; upper bits are 0.
- sd_rd, sd_wr  out  1 each  SD request.
- sd_ack  in  1  host acknowledge.
- sd_buff_addr  in  8  word index within the sector.
- sd_buff_dout  in  16  read data from the host.
- sd_buff_wr  in  1  host write strobe.
- ram_b_addr  out  12  BRAM port B word address.
- ram_b_data  out  16  BRAM port B write data.
- ram_b_we  out  1  BRAM port B write enable.
- bk_ena  out  1  save file is valid.
- bk_pending  out  1  unsaved core writes exist.
- bk_busy  out  1  transfer in progress (LED).
- bk_loading  out  1  load in progress; held in core reset.

## Operation
- **bk_ena**
  - Cleared on the rising edge of downloading.
  - Set when downloading & img_mounted & ~img_readonly.
- **bk_pending**
  - Set on core_wr & bk_ena & ~osd_open.
  - Cleared in the cycle any transfer starts.
  - If a set and a clear fall in the same cycle, clear wins.
- **Triggers**, evaluated in IDLE only:
  - Load: rising edge of load_req.
  - Auto-load: falling edge of downloading & img_nonempty & bk_ena.
  - Save: rising edge of save_req, or rising edge of (bk_pending & osd_open & autosave_en).
  - Load and auto-load need bk_ena; so do save and autosave.
  - Priority: load/auto-load > save > format.
  - Edges that occur outside IDLE are dropped.
- **State machine:** IDLE → REQ → XFER → (REQ | IDLE); separate branch IDLE → FMT → IDLE.
  - **IDLE → REQ** on a load or save trigger:
    - sd_lba=0.
    - bk_busy=1.
    - bk_loading=1 for a load.
    - sd_rd=load, sd_wr=~load.
  - **REQ:** hold sd_rd/sd_wr until sd_ack rises; clear both in the cycle after the rise; go to XFER.
  - **XFER:** on sd_ack fall:
    - If sd_lba==SECTORS-1: go to IDLE and clear bk_busy and bk_loading.
    - Otherwise: sd_lba+1, reassert the same request, go to REQ.
  - **FMT:** four cycles with ram_b_we=1, address k=0..3, data DEF_HDR[k]; then IDLE. bk_busy stays 0.
- **Port B mux** (combinational):
  - In FMT: address {10'b0,k}, data DEF_HDR[k].
  - Otherwise: address {sd_lba[3:0],sd_buff_addr}, data sd_buff_dout, ram_b_we = sd_buff_wr & sd_ack & (state==XFER|REQ).

## Timing
- **Reset values:**
  - sd_lba=0.
  - sd_rd=sd_wr=0.
  - bk_ena=bk_pending=bk_busy=bk_loading=0.
  - ram_b_we=0.
  - State IDLE; edge-detect registers 0.
- **Latencies:**
  - Trigger edge to sd_rd/sd_wr asserted: 1 clk.
  - sd_ack fall to the next request: 1 clk.
  - sd_ack fall to idle after the last sector: 1 clk.
- One request is outstanding at a time. sd_lba is stable from request assertion until sd_ack falls.
- Asserting reset_n low mid-transfer aborts immediately; outputs return to reset values and the partial image is not completed.
- sd_lba rolls from SECTORS-1 only by returning to IDLE, never by wrapping.
- If sd_ack rises in the same cycle the request is asserted, the fall is still required before advancing.

## Structure
- **Package bram_save_pkg:**
  - State enum {IDLE, REQ, XFER, FMT}.
  - DEF_HDR[4] = {16'h5548, 16'h4D42, 16'h8800, 16'h8010} ("HUBM", 0x00881080).
  - Default SECTORS.
- The only sub-module is a reusable rising/falling edge detector, edge_det; it is instantiated for load_req, save_req, format_req, downloading and the autosave condition.

## Test plan
- Mount a writable image during download, then drop downloading with img_nonempty=1 → bk_loading=1; 16 rd requests with sd_lba 0..15; bk_loading falls 1 clk after the 16th ack fall.
- save_req edge with bk_ena=1 → sd_wr for LBA 0..15; a word written by the host at sd_lba=3, addr 0x10 appears at ram_b_addr 0x310 only when sd_ack=1.
- core_wr while osd_open=0 → bk_pending=1; then raise osd_open with autosave_en=1 → save starts, bk_pending clears.
- format_req edge in IDLE → ram_b_we for 4 cycles writing 0x5548, 0x4D42, 0x8800, 0x8010 at addresses 0..3; an edge while busy → no writes.
- Simultaneous load and save edges → read requests only; save_req with bk_ena=0 → no request.
- reset_n low during sector 7 → sd_rd=0, bk_busy=0 and sd_lba=0 asynchronously.

Source files
------------

// File: rtl/bram_save_pkg.sv
// bram_save_pkg: shared types and constants for the backup RAM save/load sequencer.
//   state_t      - sequencer states
//   SECTORS_DEF  - default number of 256-word sectors per backup image
//   def_hdr()    - empty BRAM header ("HUBM", 0x00881080) written by a format
package bram_save_pkg;

  localparam int SECTORS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    FMT  = 2'd3
  } state_t;

  function automatic logic [15:0] def_hdr(input logic [1:0] k);
    case (k)
      2'd0:    def_hdr = 16'h5548;
      2'd1:    def_hdr = 16'h4D42;
      2'd2:    def_hdr = 16'h8800;
      default: def_hdr = 16'h8010;
    endcase
  endfunction

endpackage

// File: rtl/bram_save_ctrl_if.sv
// bram_save_ctrl_if: SD-image handshake plus BRAM port B bus.
//   sd_lba/sd_rd/sd_wr         - sector request from the sequencer
//   sd_ack                     - host acknowledge, high while a sector moves
//   sd_buff_addr/dout/wr       - host word index, read data and write strobe
//   ram_b_addr/data/we         - BRAM port B write side
// master = sequencer, slave = host / RAM side.
interface bram_save_ctrl_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [11:0] ram_b_addr;
  logic [15:0] ram_b_data;
  logic        ram_b_we;

  modport master (
    output sd_lba, sd_rd, sd_wr, ram_b_addr, ram_b_data, ram_b_we,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, ram_b_addr, ram_b_data, ram_b_we,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/bram_save_ctrl_edge_det.sv
// edge_det: single-bit rising/falling edge detector.
//   clk_sys, reset_n - clock, async active-low reset (history clears to 0)
//   din              - level to watch
//   rise, fall       - one-cycle pulses, valid in the cycle din changes
module edge_det (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic din_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) din_q <= 1'b0;
    else          din_q <= din;
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;
endmodule

// File: rtl/bram_save_ctrl.sv
// bram_save_ctrl: moves the backup RAM image between BRAM port B and the SD
// image one sector at a time; also auto-load after cart download, autosave
// and format.
//   clk_sys, reset_n                 - clock, async active-low reset
//   downloading, img_mounted,
//   img_readonly, img_nonempty       - cart download / image mount status
//   load_req, save_req, format_req   - OSD levels (edge-detected here)
//   autosave_en, osd_open, core_wr   - autosave controls, core BRAM writes
//   bus                              - SD handshake and BRAM port B
//   bk_ena, bk_pending, bk_busy,
//   bk_loading                       - status outputs
//
// state | meaning
// IDLE  | waiting for a load/save/format trigger
// REQ   | sd_rd or sd_wr held until sd_ack rises
// XFER  | host moving the sector; advance on sd_ack fall
// FMT   | writing the four header words to BRAM
module bram_save_ctrl
  import bram_save_pkg::*;
#(
  parameter int SECTORS = SECTORS_DEF,
  parameter int LBA_W   = 4
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             downloading,
  input  logic             img_mounted,
  input  logic             img_readonly,
  input  logic             img_nonempty,
  input  logic             load_req,
  input  logic             save_req,
  input  logic             format_req,
  input  logic             autosave_en,
  input  logic             osd_open,
  input  logic             core_wr,
  bram_save_ctrl_if.master bus,
  output logic             bk_ena,
  output logic             bk_pending,
  output logic             bk_busy,
  output logic             bk_loading
);
  localparam logic [LBA_W-1:0] LAST_LBA = LBA_W'(SECTORS - 1);

  state_t           state_q, state_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic [1:0]       fmt_k_q, fmt_k_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic             busy_q, busy_d, loading_q, loading_d;
  logic             is_load_q, is_load_d;
  logic             ack_q, start_xfer;

  logic load_rise, load_fall, save_rise, save_fall, fmt_rise, fmt_fall;
  logic dl_rise, dl_fall, auto_rise, auto_fall;
  logic unused_falls;

  edge_det u_load (.clk_sys, .reset_n, .din(load_req),    .rise(load_rise), .fall(load_fall));
  edge_det u_save (.clk_sys, .reset_n, .din(save_req),    .rise(save_rise), .fall(save_fall));
  edge_det u_fmt  (.clk_sys, .reset_n, .din(format_req),  .rise(fmt_rise),  .fall(fmt_fall));
  edge_det u_dl   (.clk_sys, .reset_n, .din(downloading), .rise(dl_rise),   .fall(dl_fall));
  edge_det u_auto (.clk_sys, .reset_n, .din(bk_pending & osd_open & autosave_en),
                   .rise(auto_rise), .fall(auto_fall));

  assign unused_falls = load_fall ^ save_fall ^ fmt_fall ^ auto_fall;

  logic load_trig, save_trig, ack_rise, ack_fall;
  assign load_trig = bk_ena & (load_rise | (dl_fall & img_nonempty));
  assign save_trig = bk_ena & (save_rise | auto_rise);
  assign ack_rise  = bus.sd_ack & ~ack_q;
  assign ack_fall  = ~bus.sd_ack & ack_q;

  always_comb begin
    state_d    = state_q;
    lba_d      = lba_q;
    fmt_k_d    = fmt_k_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    busy_d     = busy_q;
    loading_d  = loading_q;
    is_load_d  = is_load_q;
    start_xfer = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_trig || save_trig) begin
          // load wins when both fire in the same cycle
          state_d    = REQ;
          lba_d      = '0;
          busy_d     = 1'b1;
          loading_d  = load_trig;
          is_load_d  = load_trig;
          rd_d       = load_trig;
          wr_d       = ~load_trig;
          start_xfer = 1'b1;
        end else if (fmt_rise) begin
          state_d = FMT;
          fmt_k_d = 2'd0;
        end
      end
      REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ack_fall) begin
          if (lba_q == LAST_LBA) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            loading_d = 1'b0;
          end else begin
            lba_d   = lba_q + LBA_W'(1);
            rd_d    = is_load_q;
            wr_d    = ~is_load_q;
            state_d = REQ;
          end
        end
      end
      FMT: begin
        fmt_k_d = fmt_k_q + 2'd1;
        if (fmt_k_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lba_q     <= '0;
      fmt_k_q   <= 2'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      loading_q <= 1'b0;
      is_load_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      fmt_k_q   <= fmt_k_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      loading_q <= loading_d;
      is_load_q <= is_load_d;
      ack_q     <= bus.sd_ack;
    end
  end

  // A mount during download sets bk_ena even if downloading rose that cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bk_ena     <= 1'b0;
      bk_pending <= 1'b0;
    end else begin
      if (downloading && img_mounted && !img_readonly) bk_ena <= 1'b1;
      else if (dl_rise)                                bk_ena <= 1'b0;
      if (start_xfer)                                  bk_pending <= 1'b0;
      else if (core_wr && bk_ena && !osd_open)         bk_pending <= 1'b1;
    end
  end

  assign bus.sd_lba     = 32'(lba_q);
  assign bus.sd_rd      = rd_q;
  assign bus.sd_wr      = wr_q;
  assign bk_busy        = busy_q;
  assign bk_loading     = loading_q;

  assign bus.ram_b_we   = (state_q == FMT) |
                          (bus.sd_buff_wr & bus.sd_ack & (state_q == XFER || state_q == REQ));
  assign bus.ram_b_addr = (state_q == FMT) ? {10'b0, fmt_k_q} : 12'({lba_q, bus.sd_buff_addr});
  assign bus.ram_b_data = (state_q == FMT) ? def_hdr(fmt_k_q) : bus.sd_buff_dout;

endmodule

// File: tb/tb_bram_save_ctrl.sv
module tb_bram_save_ctrl;
  localparam int SECTORS = 16;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic downloading = 0, img_mounted = 0, img_readonly = 0, img_nonempty = 0;
  logic load_req = 0, save_req = 0, format_req = 0;
  logic autosave_en = 0, osd_open = 0, core_wr = 0;
  logic bk_ena, bk_pending, bk_busy, bk_loading;

  bram_save_ctrl_if bus();

  bram_save_ctrl #(.SECTORS(SECTORS), .LBA_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .downloading(downloading),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_nonempty(img_nonempty),
    .load_req(load_req), .save_req(save_req), .format_req(format_req),
    .autosave_en(autosave_en), .osd_open(osd_open), .core_wr(core_wr),
    .bus(bus), .bk_ena(bk_ena), .bk_pending(bk_pending),
    .bk_busy(bk_busy), .bk_loading(bk_loading)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { bit is_rd; int unsigned lba; } req_t;
  typedef struct { logic [11:0] addr; logic [15:0] data; } wr_t;
  req_t exp_req[$];
  wr_t  exp_wr[$];
  logic [15:0] hdr [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // scoreboard monitor
  bit   prev_req = 0;
  bit   cur_req;
  req_t mr;
  wr_t  mw;
  always @(negedge clk_sys) begin
    if (!reset_n) prev_req = 0;
    else begin
      cur_req = bus.sd_rd | bus.sd_wr;
      if (cur_req && !prev_req) begin
        if (exp_req.size() == 0)
          fail("unexpected_req", $sformatf("got rd=%0b wr=%0b lba=%0d, required none",
                                           bus.sd_rd, bus.sd_wr, bus.sd_lba));
        else begin
          mr = exp_req.pop_front();
          chk("req_kind", {30'd0, bus.sd_rd, bus.sd_wr}, mr.is_rd ? 32'd2 : 32'd1);
          chk("req_lba", bus.sd_lba, mr.lba);
        end
      end
      prev_req = cur_req;
      if (bus.ram_b_we) begin
        if (exp_wr.size() == 0)
          fail("unexpected_ram_we", $sformatf("got addr=%0h data=%0h, required none",
                                              bus.ram_b_addr, bus.ram_b_data));
        else begin
          mw = exp_wr.pop_front();
          chk("ram_addr", {20'd0, bus.ram_b_addr}, {20'd0, mw.addr});
          chk("ram_data", {16'd0, bus.ram_b_data}, {16'd0, mw.data});
        end
      end
    end
  end

  task automatic push_image(input bit is_rd);
    req_t r;
    for (int i = 0; i < SECTORS; i++) begin
      r.is_rd = is_rd;
      r.lba   = i;
      exp_req.push_back(r);
    end
  endtask

  task automatic push_format();
    wr_t w;
    for (int k = 0; k < 4; k++) begin
      w.addr = 12'(k);
      w.data = hdr[k];
      exp_wr.push_back(w);
    end
  endtask

  task automatic wait_req(output bit ok);
    int t = 0;
    while (!(bus.sd_rd | bus.sd_wr) && t < 40) begin
      step();
      t++;
    end
    ok = bus.sd_rd | bus.sd_wr;
    if (!ok) fail("req_timeout", "no request within 40 cycles");
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d, input int s);
    wr_t w;
    w.addr = 12'(s * 256 + int'(a));
    w.data = d;
    exp_wr.push_back(w);
    bus.sd_buff_addr = a;
    bus.sd_buff_dout = d;
    bus.sd_buff_wr   = 1'b1;
    step();
    bus.sd_buff_wr   = 1'b0;
  endtask

  // host side of n sectors, starting at sector 0
  task automatic serve(input int n, input bit is_load);
    bit ok;
    for (int s = 0; s < n; s++) begin
      wait_req(ok);
      if (!ok) return;
      if (s == 5) begin
        // strobe without acknowledge must not reach the BRAM
        bus.sd_buff_addr = 8'h20;
        bus.sd_buff_dout = 16'hDEAD;
        bus.sd_buff_wr   = 1'b1;
        step();
        bus.sd_buff_wr   = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
      bus.sd_ack = 1'b1;
      step();
      chk("req_drop", {31'd0, bus.sd_rd | bus.sd_wr}, 32'd0);
      chk("loading_during", {31'd0, bk_loading}, {31'd0, is_load});
      chk("busy_during", {31'd0, bk_busy}, 32'd1);
      if (s == 3) host_write(8'h10, 16'hA5C3, s);
      repeat ($urandom_range(0, 2)) host_write(8'($urandom), 16'($urandom), s);
      bus.sd_ack = 1'b0;
      step();
      if (s == SECTORS - 1) begin
        chk("busy_end", {31'd0, bk_busy}, 32'd0);
        chk("loading_end", {31'd0, bk_loading}, 32'd0);
      end else begin
        chk("next_req_latency", {31'd0, bus.sd_rd | bus.sd_wr}, 32'd1);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.sd_ack = 0; bus.sd_buff_addr = 0; bus.sd_buff_dout = 0; bus.sd_buff_wr = 0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_lba", bus.sd_lba, 32'd0);
    chk("rst_rd_wr", {30'd0, bus.sd_rd, bus.sd_wr}, 32'd0);
    chk("rst_status", {28'd0, bk_ena, bk_pending, bk_busy, bk_loading}, 32'd0);
    chk("rst_we", {31'd0, bus.ram_b_we}, 32'd0);

    // save without a valid file: nothing happens
    save_req = 1; step(); save_req = 0;
    repeat (4) step();
    chk("save_no_ena", {30'd0, bus.sd_rd, bus.sd_wr}, 32'd0);

    // mount during download, then auto-load
    downloading = 1; step();
    img_mounted = 1; step(); img_mounted = 0;
    step();
    chk("ena_set", {31'd0, bk_ena}, 32'd1);
    img_nonempty = 1;
    push_image(1);
    downloading = 0; step();
    chk("autoload_latency", {31'd0, bus.sd_rd}, 32'd1);
    chk("autoload_loading", {31'd0, bk_loading}, 32'd1);
    serve(SECTORS, 1);

    // manual save
    push_image(0);
    save_req = 1; step(); save_req = 0;
    chk("save_latency", {31'd0, bus.sd_wr}, 32'd1);
    serve(SECTORS, 0);

    // autosave on OSD open
    core_wr = 1; step(); core_wr = 0;
    chk("pending_set", {31'd0, bk_pending}, 32'd1);
    push_image(0);
    autosave_en = 1; osd_open = 1; step();
    chk("autosave_start", {31'd0, bus.sd_wr}, 32'd1);
    chk("pending_clear", {31'd0, bk_pending}, 32'd0);
    serve(SECTORS, 0);
    osd_open = 0; autosave_en = 0;
    step();

    // format
    push_format();
    format_req = 1; step(); format_req = 0;
    chk("fmt_we", {31'd0, bus.ram_b_we}, 32'd1);
    chk("fmt_not_busy", {31'd0, bk_busy}, 32'd0);
    repeat (5) step();

    // format edge while busy is dropped
    push_image(1);
    load_req = 1; step(); load_req = 0;
    format_req = 1; step(); format_req = 0;
    serve(SECTORS, 1);

    // simultaneous load and save: load wins
    push_image(1);
    load_req = 1; save_req = 1; step(); load_req = 0; save_req = 0;
    chk("both_is_load", {30'd0, bus.sd_rd, bus.sd_wr}, 32'd2);
    serve(SECTORS, 1);

    // random operations
    for (int it = 0; it < 4; it++) begin
      case ($urandom_range(0, 2))
        0: begin push_image(1); load_req = 1; step(); load_req = 0; serve(SECTORS, 1); end
        1: begin push_image(0); save_req = 1; step(); save_req = 0; serve(SECTORS, 0); end
        default: begin push_format(); format_req = 1; step(); format_req = 0; repeat (5) step(); end
      endcase
      repeat ($urandom_range(1, 4)) step();
    end

    // reset in the middle of sector 7
    push_image(1);
    load_req = 1; step(); load_req = 0;
    serve(7, 1);
    wait_req(ok);
    chk("abort_lba_before", bus.sd_lba, 32'd7);
    bus.sd_ack = 1; step();
    reset_n = 0;
    #1;
    chk("abort_rd", {31'd0, bus.sd_rd}, 32'd0);
    chk("abort_busy", {31'd0, bk_busy}, 32'd0);
    chk("abort_lba", bus.sd_lba, 32'd0);
    chk("abort_loading", {31'd0, bk_loading}, 32'd0);
    exp_req.delete();
    bus.sd_ack = 0;
    step(); step();
    reset_n = 1;
    step();

    // mount, drop download with empty image (no load), then download clears bk_ena
    img_nonempty = 0;
    downloading = 1; step();
    img_mounted = 1; step(); img_mounted = 0;
    downloading = 0; step();
    repeat (3) step();
    chk("empty_no_load", {30'd0, bus.sd_rd, bus.sd_wr}, 32'd0);
    chk("ena_kept", {31'd0, bk_ena}, 32'd1);
    downloading = 1; step();
    chk("ena_cleared", {31'd0, bk_ena}, 32'd0);
    downloading = 0;
    repeat (3) step();

    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
